// File: rtl/neo_lbuf_mix.sv
// Double-banked sprite line buffer with fix overlay; read path RD_CE -> PA is 2 cycles, one pixel/cycle.
// Writer accepts one 2-pixel pair per 2 cycles via WR_READY; not ready during the power-up clear sweep.
module neo_lbuf_mix #(
    parameter int AW        = 9,
    parameter int COL_W     = 4,
    parameter int PAL_W     = 8,
    parameter int FIX_PAL_W = 4,
    localparam int PA_W     = PAL_W + COL_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 WR_LOAD,
    input  logic [AW-1:0]        WR_ADDR,
    input  logic                 WR_EN,
    output logic                 WR_READY,
    input  logic [2*COL_W-1:0]   WR_PIX,
    input  logic [PAL_W-1:0]     WR_PAL,
    input  logic                 WR_FLIP,
    input  logic                 SWAP,
    input  logic [AW-1:0]        RD_START,
    input  logic                 RD_CE,
    input  logic [COL_W-1:0]     FIX_PIX,
    input  logic [FIX_PAL_W-1:0] FIX_PAL,
    input  logic                 CHBL,
    input  logic                 CPU_ACCESS,
    input  logic [PA_W-1:0]      CPU_ADDR,
    output logic [PA_W-1:0]      PA,
    output logic                 INIT_DONE,
    output logic                 COLLIDE
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_PIX1} state_t;

    state_t state, state_nxt;

    logic [PA_W-1:0] bank0 [2**AW];
    logic [PA_W-1:0] bank1 [2**AW];

    logic [AW:0]        init_cnt;
    logic               sel, sel_nxt, collide;
    logic [AW-1:0]      wptr, wptr_nxt, rptr;
    logic [COL_W-1:0]   pend_pix;
    logic [PAL_W-1:0]   pend_pal;
    logic               pend_flip;
    logic               swap_eff, rd_eff, accept;

    logic               wr_vld, wr_bank;
    logic [AW-1:0]      wr_addr;
    logic [PA_W-1:0]    wr_dat;

    logic               clr_vld, clr_bank;
    logic [AW-1:0]      clr_addr;

    logic [1:0]         we;
    logic [AW-1:0]      wa [2];
    logic [PA_W-1:0]    wd [2];

    logic               rd_vld_q, chbl_q;
    logic [PA_W-1:0]    rd_dat_q, pa_vid;
    logic [COL_W-1:0]   fix_pix_q;
    logic [FIX_PAL_W-1:0] fix_pal_q;

    assign swap_eff = SWAP && (state != S_INIT);
    assign rd_eff   = RD_CE && (state != S_INIT) && !SWAP;
    assign sel_nxt  = sel ^ swap_eff;

    always_ff @(posedge CLK) begin
        if (RST) state <= S_INIT;
        else     state <= state_nxt;
    end

    // WPTR holds the pair start; pixel1 sits one step away in the flip direction.
    always_comb begin
        state_nxt = state;
        wr_vld    = 1'b0;
        wr_bank   = ~sel_nxt;
        wr_addr   = wptr;
        wr_dat    = '0;
        wptr_nxt  = wptr;
        accept    = 1'b0;
        case (state)
            S_INIT: begin
                if (init_cnt[AW]) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (WR_LOAD) wptr_nxt = WR_ADDR;
                if (WR_EN) begin
                    accept    = 1'b1;
                    wr_addr   = wptr_nxt;
                    wr_dat    = {WR_PAL, WR_PIX[COL_W-1:0]};
                    wr_vld    = |WR_PIX[COL_W-1:0];
                    state_nxt = S_PIX1;
                end
            end
            S_PIX1: begin
                state_nxt = S_IDLE;
                if (WR_LOAD) wptr_nxt = WR_ADDR;
                if (!swap_eff) begin
                    wr_addr = pend_flip ? wptr - 1'b1 : wptr + 1'b1;
                    wr_dat  = {pend_pal, pend_pix};
                    wr_vld  = |pend_pix;
                    if (!WR_LOAD) wptr_nxt = pend_flip ? wptr - AW'(2) : wptr + AW'(2);
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            init_cnt  <= '0;
            sel       <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            collide   <= 1'b0;
            pend_pix  <= '0;
            pend_pal  <= '0;
            pend_flip <= 1'b0;
        end else begin
            if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
            sel  <= sel_nxt;
            wptr <= wptr_nxt;
            if (swap_eff)    rptr <= RD_START;
            else if (rd_eff) rptr <= rptr + 1'b1;
            if (swap_eff && state == S_PIX1) collide <= 1'b1;
            if (accept) begin
                pend_pix  <= WR_PIX[2*COL_W-1:COL_W];
                pend_pal  <= WR_PAL;
                pend_flip <= WR_FLIP;
            end
        end
    end

    // Per-bank write port: sweep, then writer, then the deferred read-clear.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            we[b] = 1'b0;
            wa[b] = wr_addr;
            wd[b] = wr_dat;
            if (state == S_INIT) begin
                we[b] = !init_cnt[AW];
                wa[b] = init_cnt[AW-1:0];
                wd[b] = '0;
            end else if (wr_vld && wr_bank == b[0]) begin
                we[b] = 1'b1;
            end else if (clr_vld && clr_bank == b[0]) begin
                we[b] = 1'b1;
                wa[b] = clr_addr;
                wd[b] = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (we[0]) bank0[wa[0]] <= wd[0];
        if (we[1]) bank1[wa[1]] <= wd[1];
        if (rd_eff) begin
            rd_dat_q  <= sel ? bank1[rptr] : bank0[rptr];
            fix_pix_q <= FIX_PIX;
            fix_pal_q <= FIX_PAL;
            chbl_q    <= CHBL;
        end
        clr_bank <= sel;
        clr_addr <= rptr;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_vld_q <= 1'b0;
            clr_vld  <= 1'b0;
            pa_vid   <= '0;
        end else begin
            rd_vld_q <= rd_eff;
            clr_vld  <= rd_eff;
            if (rd_vld_q) begin
                if (chbl_q)              pa_vid <= '0;
                else if (|fix_pix_q)     pa_vid <= {PAL_W'(fix_pal_q), fix_pix_q};
                else                     pa_vid <= rd_dat_q;
            end
        end
    end

    assign PA        = CPU_ACCESS ? CPU_ADDR : pa_vid;
    assign WR_READY  = (state == S_IDLE);
    assign INIT_DONE = (state != S_INIT);
    assign COLLIDE   = collide;

endmodule

// File: tb/tb_neo_lbuf_mix.sv
// Directed bench for neo_lbuf_mix at AW=4 (16-entry banks, 12-bit palette address).
module tb_neo_lbuf_mix;

    localparam int AW = 4;
    localparam int N  = 2**AW;

    logic        clk = 1'b0;
    logic        rst, wr_load, wr_en, wr_ready, wr_flip, swap, rd_ce, chbl, cpu_access;
    logic [3:0]  wr_addr, rd_start, fix_pix, fix_pal;
    logic [7:0]  wr_pix, wr_pal;
    logic [11:0] cpu_addr, pa;
    logic        init_done, collide;

    int          n_chk = 0;
    int          n_err = 0;
    logic [11:0] exp_q [N];

    neo_lbuf_mix #(.AW(AW), .COL_W(4), .PAL_W(8), .FIX_PAL_W(4)) dut (
        .CLK(clk), .RST(rst), .WR_LOAD(wr_load), .WR_ADDR(wr_addr), .WR_EN(wr_en),
        .WR_READY(wr_ready), .WR_PIX(wr_pix), .WR_PAL(wr_pal), .WR_FLIP(wr_flip),
        .SWAP(swap), .RD_START(rd_start), .RD_CE(rd_ce), .FIX_PIX(fix_pix),
        .FIX_PAL(fix_pal), .CHBL(chbl), .CPU_ACCESS(cpu_access), .CPU_ADDR(cpu_addr),
        .PA(pa), .INIT_DONE(init_done), .COLLIDE(collide)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!wr_ready && n < 100) begin
            tick();
            n++;
        end
        chk_val(tag, n, N + 1);
        chk_val({tag, "_done"}, init_done, 1);
    endtask

    task automatic write_pair(input logic load, input logic [3:0] addr, input logic [3:0] p0,
                              input logic [3:0] p1, input logic [7:0] pal, input logic flip);
        int k = 0;
        while (!wr_ready && k < 20) begin
            tick();
            k++;
        end
        chk_val("wr_ready_idle", wr_ready, 1);
        wr_en = 1; wr_load = load; wr_addr = addr; wr_pix = {p1, p0}; wr_pal = pal; wr_flip = flip;
        tick();
        wr_en = 0; wr_load = 0;
        chk_val("wr_ready_pix1", wr_ready, 0);
        tick();
    endtask

    task automatic do_swap(input logic [3:0] start);
        swap = 1; rd_start = start;
        tick();
        swap = 0;
    endtask

    // Back-to-back reads; entry i appears on PA two edges after its RD_CE.
    task automatic read_seq(input int n, input string tag);
        for (int i = 0; i <= n; i++) begin
            rd_ce = (i < n);
            tick();
            if (i >= 1) chk_val($sformatf("%s[%0d]", tag, i - 1), pa, exp_q[i - 1]);
        end
        rd_ce = 0;
    endtask

    initial begin
        rst = 1; wr_load = 0; wr_en = 0; wr_flip = 0; swap = 0; rd_ce = 0; chbl = 0;
        cpu_access = 0; wr_addr = 0; rd_start = 0; fix_pix = 0; fix_pal = 0;
        wr_pix = 0; wr_pal = 0; cpu_addr = 0;
        for (int i = 0; i < N; i++) exp_q[i] = '0;

        repeat (3) tick();
        chk_val("rst_pa", pa, 0);
        chk_val("rst_ready", wr_ready, 0);
        chk_val("rst_init_done", init_done, 0);
        chk_val("rst_collide", collide, 0);
        rst = 0;
        wait_init("init_cycles");

        // Both banks cleared by the sweep
        read_seq(N, "clr_b0");
        do_swap(0);
        read_seq(N, "clr_b1");

        // Basic pair at 10, then the read pass clears it
        write_pair(1, 4'd10, 4'd3, 4'd5, 8'h12, 0);
        do_swap(10);
        exp_q[0] = 12'h123; exp_q[1] = 12'h125;
        read_seq(2, "pair");
        do_swap(10);
        do_swap(10);
        exp_q[0] = 12'h000; exp_q[1] = 12'h000;
        read_seq(2, "reread");

        // Flipped pairs wrapping through address 0
        write_pair(1, 4'd0, 4'd3, 4'd5, 8'h12, 1);
        write_pair(0, 4'd0, 4'd7, 4'd9, 8'h34, 1);
        do_swap(13);
        exp_q[0] = 12'h349; exp_q[1] = 12'h347; exp_q[2] = 12'h125; exp_q[3] = 12'h123;
        read_seq(4, "flip");

        // Transparent pixel0 preserves the old entry
        write_pair(1, 4'd4, 4'd7, 4'hA, 8'h0A, 0);
        write_pair(1, 4'd4, 4'd0, 4'hB, 8'h55, 0);
        do_swap(4);
        exp_q[0] = 12'h0A7; exp_q[1] = 12'h55B;
        read_seq(2, "transp");

        // SWAP while pixel1 is pending
        chk_val("collide_before", collide, 0);
        wr_en = 1; wr_load = 1; wr_addr = 4'd7; wr_pix = 8'h21; wr_pal = 8'h66; wr_flip = 0;
        tick();
        wr_en = 0; wr_load = 0;
        do_swap(6);
        chk_val("collide_set", collide, 1);
        chk_val("collide_ready", wr_ready, 1);
        exp_q[0] = 12'h000; exp_q[1] = 12'h661; exp_q[2] = 12'h000;
        read_seq(3, "collide_rd");
        do_swap(8);
        exp_q[0] = 12'h000;
        read_seq(1, "collide_other");

        // Fix overlay, blanking, CPU override
        fix_pix = 4'd6; fix_pal = 4'd3;
        exp_q[0] = 12'h036;
        read_seq(1, "fix");
        chbl = 1;
        exp_q[0] = 12'h000;
        read_seq(1, "chbl");
        chbl = 0; fix_pix = 0; fix_pal = 0;
        cpu_access = 1; cpu_addr = 12'hABC;
        #1;
        chk_val("cpu_pa", pa, 12'hABC);
        cpu_access = 0;
        #1;
        chk_val("cpu_release", pa, 12'h000);
        chk_val("collide_sticky", collide, 1);

        // Reset in the middle of a pair
        wr_en = 1; wr_addr = 4'd2; wr_pix = 8'h33; wr_pal = 8'h77;
        tick();
        wr_en = 0;
        rst = 1;
        tick();
        chk_val("rst2_collide", collide, 0);
        chk_val("rst2_ready", wr_ready, 0);
        chk_val("rst2_init_done", init_done, 0);
        rst = 0;
        wait_init("init2_cycles");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/neo_lbuf_mix.md
# neo_lbuf_mix

Parametrised double-banked sprite line buffer with built-in fix overlay and palette-address output. It sits between the sprite pixel fetch and palette RAM, in the same position as the NEO-B1 line-buffer stage, but runs on a single system clock with enables. It adds the following over the NEO-B1 stage:
- configurable depth and widths;
- a write-acceptance handshake;
- horizontal-flip addressing;
- a power-up clear sweep;
- collision flagging on bank swap.

## Interface
- AW, 9: line-buffer address width; each bank holds 2^AW entries.
- COL_W, 4: colour index width per pixel.
- PAL_W, 8: sprite palette number width.
- FIX_PAL_W, 4: fix palette number width. Must be ≤ PAL_W.
- PA_W is derived as PAL_W+COL_W and is not overridable.

- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- WR_LOAD  in  1  load the write pointer from WR_ADDR.
- WR_ADDR  in  AW  write start address.
- WR_EN  in  1  offer a 2-pixel pair.
- WR_READY  out  1  pair accepted on cycles where WR_EN&WR_READY.
- WR_PIX  in  2*COL_W  pixel0=[COL_W-1:0], pixel1=upper.
- WR_PAL  in  PAL_W  palette for the pair.
- WR_FLIP  in  1  1: addresses decrement, 0: increment.
- SWAP  in  1  line boundary: exchange the banks.
- RD_START  in  AW  read pointer start, loaded on SWAP.
- RD_CE  in  1  pixel enable; reads and clears one entry.
- FIX_PIX  in  COL_W  fix pixel, sampled with RD_CE.
- FIX_PAL  in  FIX_PAL_W  fix palette, sampled with RD_CE.
- CHBL  in  1  blanking, sampled with RD_CE.
- CPU_ACCESS  in  1  CPU owns the palette bus.
- CPU_ADDR  in  PA_W  CPU palette address.
- PA  out  PA_W  palette address.
- INIT_DONE  out  1  clear sweep finished.
- COLLIDE  out  1  sticky flag: a pending pixel was dropped by SWAP.

## Operation
**Storage**
- Two banks, each 2^AW × PA_W, holding {palette, colour}.
- SEL selects the read bank; the other bank is the write bank.
- Each bank has one write port, driven by the writer when it is the write bank and by the clearer when it is the read bank.

**FSM**
- INIT:
  - Entered on RST.
  - A counter sweeps addresses 0..2^AW-1, writing 0 to both banks, one address per cycle.
  - WR_READY=0, INIT_DONE=0, and RD_CE is ignored.
  - Goes to IDLE after the last address, taking 2^AW cycles.
- IDLE:
  - WR_READY=1.
  - On WR_EN: latch the pair, WR_PAL and WR_FLIP; write pixel0 at WPTR; go to PIX1.
- PIX1:
  - WR_READY=0.
  - Write pixel1 at WPTR±1 (− if the latched flip is set).
  - WPTR ← WPTR±2.
  - Go to IDLE.

**Pixel writes and pointer**
- A pixel with colour 0 is transparent: no write is made, but the pointer still advances.
- All address arithmetic is modulo 2^AW and wraps silently.
- WR_LOAD sets WPTR in any state except INIT.
  - If it coincides with an accept, pixel0 uses WR_ADDR.
  - The address of a pixel already pending in PIX1 is unaffected.

**Read path** (for each RD_CE)
- Read bank[SEL][RPTR], then write 0 to that entry (clear-after-read), then RPTR ← RPTR+1.
- The output stage selects, in priority order:
  - 0 if CHBL.
  - Otherwise {zero-pad, FIX_PAL, FIX_PIX} if FIX_PIX≠0.
  - Otherwise the buffer entry.
- The selected value is registered into PA_VID.

**Output and swap**
- PA = CPU_ACCESS ? CPU_ADDR : PA_VID. This mux is combinational.
- SWAP does the following:
  - SEL toggles and RPTR ← RD_START. WPTR is unchanged.
  - If the FSM is in PIX1, the pending pixel1 is dropped, COLLIDE ← 1, and the FSM goes to IDLE.
  - SWAP is ignored during INIT.

**Simultaneous events**
- SWAP+WR_EN in IDLE: the swap applies first, and pixel0 goes into the new write bank.
- SWAP+RD_CE: the swap wins; no read and no clear that cycle.
- COLLIDE clears only on RST.

## Timing
**Reset values**
- SEL=0, WPTR=0, RPTR=0.
- PA_VID=0, so PA=0 unless CPU_ACCESS.
- WR_READY=0, INIT_DONE=0, COLLIDE=0.

**Latencies**
- RD_CE sampled at cycle t → RAM data available at t+1 → PA_VID updated at t+2.
- FIX_PIX, FIX_PAL and CHBL are delayed one stage internally so they stay aligned with the RAM data.
- RD_CE may be asserted every cycle; PA then has throughput of one pixel per cycle.
- The clear write occurs at cycle t+1 to the address read at t.

**Write side**
- Throughput is one pair per 2 cycles.
- A write lands in RAM on the cycle it is issued.
- INIT_DONE rises together with WR_READY, 2^AW+1 cycles after RST deasserts.

**RST mid-operation**
- Aborts any pair; pending pixels are lost.
- Restarts the INIT sweep.

## Test plan
- Reset, then count cycles until WR_READY=1 → exactly 2^AW+1 cycles; all entries of both banks read back as 0.
- WR_LOAD 10, one pair (pix 3,5; pal 0x12), SWAP with RD_START 10, then 2 RD_CE → PA=0x123 and then 0x125, at t+2 each; a second read pass of the same entries → 0,0.
- Same pair with WR_FLIP=1, WR_ADDR=0 → the entry at address 0 holds pixel0 and the entry at address 2^AW-1 holds pixel1 (wrap); WPTR ends at 2^AW-2.
- Pair with pixel0=0 over a previously written entry 0x0A7 → 0x0A7 is preserved; pixel1 is written at the next address.
- SWAP asserted in PIX1 → COLLIDE=1, pixel1 absent from both banks; WR_READY=1 on the next cycle.
- RD_CE with FIX_PIX=6, FIX_PAL=3 → PA=0x036; add CHBL=1 → PA=0; CPU_ACCESS=1 with CPU_ADDR=0xABC → PA=0xABC in the same cycle.
